// File: rtl/wisc_pkg.sv
// Shared ISA constants and fetch-stage types.
// Imported by fetch_unit and fetch_pc_reg.
package wisc_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_t;

  function automatic logic [4:0] opcode(
    input logic [INSTR_W-1:0] w
  );
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect load, +2 increment and hold.
// Load has priority over increment.
module fetch_pc_reg
  import wisc_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] load_pc_i,
  input  logic               inc_i,
  output logic [INSTR_W-1:0] pc_o
);

  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + INSTR_W'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, redirect squash, HALT stop.
// Optional macro FETCH_ALIGN_ERR_EN adds the err port for misaligned redirects.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_done,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc_plus2,
  output logic               instr_valid,
`ifdef FETCH_ALIGN_ERR_EN
  output logic               halted,
  output logic               err
`else
  output logic               halted
`endif
);

  fetch_state_t       state_q;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] pcp2_q;
  logic               valid_q;
  logic               halted_q;
  logic               outst_q;
  logic               squash_q;
  logic [INSTR_W-1:0] tgt;
  logic               misalign;
  logic               consume;
  logic               resp;
  logic               live;
  logic               issue;

`ifdef FETCH_ALIGN_ERR_EN
  logic err_q;
  assign tgt      = redirect_pc;
  assign misalign = redirect_pc[0];
  assign err      = err_q;
`else
  assign tgt      = redirect_pc & 16'hFFFE;
  assign misalign = 1'b0;
`endif

  assign consume = valid_q && !stall;
  assign resp    = imem_done && outst_q;
  assign live    = resp && !squash_q;
  assign issue   = rst_n && !redirect
                && (state_q == FETCH) && !outst_q
                && (!valid_q || consume);

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (redirect),
    .load_pc_i (tgt),
    .inc_i     (live && !redirect),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      instr_q  <= '0;
      pcp2_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      outst_q  <= 1'b0;
      squash_q <= 1'b0;
`ifdef FETCH_ALIGN_ERR_EN
      err_q    <= 1'b0;
`endif
    end else if (redirect) begin
      state_q  <= FETCH;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      // a still-pending response must be dropped when it lands
      if (outst_q && !imem_done) begin
        squash_q <= 1'b1;
      end else begin
        squash_q <= 1'b0;
        outst_q  <= 1'b0;
      end
      if (misalign) begin
        state_q  <= HALTED;
        halted_q <= 1'b1;
`ifdef FETCH_ALIGN_ERR_EN
        err_q    <= 1'b1;
`endif
      end
    end else begin
      if (issue) begin
        outst_q <= 1'b1;
      end
      if (resp) begin
        outst_q  <= 1'b0;
        squash_q <= 1'b0;
      end
      if (live) begin
        instr_q <= imem_rdata;
        pcp2_q  <= pc + INSTR_W'(2);
        valid_q <= 1'b1;
        if (opcode(imem_rdata) == OPC_HALT) begin
          state_q <= HALTED;
        end
      end else if (consume) begin
        valid_q <= 1'b0;
      end
      halted_q <= (state_q == HALTED) && (consume || !valid_q);
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign pc_plus2    = pcp2_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule
